// File: rtl/nexus_nonce_collector.sv
// Nonce collector: buffers 64-bit candidate nonces in a small FIFO and streams
// each one out as a low/high pair of 32-bit words over a valid/ready port.
module nexus_nonce_collector #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic [63:0]             NonceIn,
  input  logic                    NonceValid,
  input  logic                    Flush,
  output logic [31:0]             OutWord,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic                    OutLast,
  output logic [$clog2(DEPTH):0]  Count,
  output logic                    Overflow,
  output logic [15:0]             DropCnt,
  output logic [1:0]              DbgState
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  // Output handshake: a word transfers on a rising edge where OutValid and
  // OutReady are both high; OutWord/OutLast never change while OutValid=1
  // and OutReady=0.
  state_t          r_state;
  logic [63:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_count;
  logic [31:0]     r_hold_hi;
  logic [31:0]     r_out_word;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_overflow;
  logic [15:0]     r_drop_cnt;

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [63:0]     w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_head  = r_mem[r_rd_ptr];

  // Flush suppresses loads so no word of old work starts after it.
  assign w_pop  = ~Flush & ~w_empty &
                  ((r_state == IDLE) | ((r_state == SEND_HI) & OutReady));
  assign w_push = NonceValid & ~Flush & (~w_full | w_pop);
  assign w_drop = NonceValid & ~Flush & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= NonceIn;
  end

  always_ff @(posedge clk) begin
    if (!nRst || Flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // The low word goes straight to the output register on load, so only the
  // upper half of the nonce needs to be held.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state     <= IDLE;
      r_hold_hi   <= '0;
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_hold_hi   <= w_head[63:32];
            r_out_word  <= w_head[31:0];
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_state     <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (Flush) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_state     <= IDLE;
          end else if (OutReady) begin
            r_out_word <= r_hold_hi;
            r_out_last <= 1'b1;
            r_state    <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (OutReady) begin
            if (w_pop) begin
              r_hold_hi   <= w_head[63:32];
              r_out_word  <= w_head[31:0];
              r_out_valid <= 1'b1;
              r_out_last  <= 1'b0;
              r_state     <= SEND_LO;
            end else begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= IDLE;
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign OutWord  = r_out_word;
  assign OutValid = r_out_valid;
  assign OutLast  = r_out_last;
  assign Count    = r_count;
  assign Overflow = r_overflow;
  assign DropCnt  = r_drop_cnt;
  assign DbgState = r_state;

endmodule
